// File: rtl/alu_op_encoder.sv
// alu_op_encoder: RV32 R/I-type arithmetic/logic decoder feeding the ALU,
// with a small in-order FIFO that absorbs execute-side stalls.
// Optional M-extension decode (mul/div/rem) is enabled by defining
// the macro ALU_OP_ENCODER_MEXT_EN.
module alu_op_encoder #(
  parameter int OP_W  = 13,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_op,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic             out_use_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_BW = $clog2(DEPTH + 1);
  localparam logic [CNT_BW-1:0] DEPTH_C = CNT_BW'(DEPTH);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1) << 0;
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1) << 1;
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(1) << 2;
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(1) << 3;
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(1) << 4;
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(1) << 5;
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(1) << 6;
  localparam logic [OP_W-1:0] OP_SRA  = OP_W'(1) << 7;
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(1) << 8;
  localparam logic [OP_W-1:0] OP_SLTU = OP_W'(1) << 9;
`ifdef ALU_OP_ENCODER_MEXT_EN
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(1) << 10;
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(1) << 11;
  localparam logic [OP_W-1:0] OP_REM  = OP_W'(1) << 12;
`endif

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic            use_imm;
    logic            illegal;
  } entry_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [6:0]         funct7;
  logic signed [11:0] imm12_p0;
  logic signed [31:0] imm_i_p0;
  logic [OP_W-1:0]    op_p0;
  logic               itype_p0;
  logic               shift_p0;
  logic               legal_p0;
  entry_t             dec_p0;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign imm12_p0 = in_instr[31:20];
  assign imm_i_p0 = 32'(imm12_p0);

  // Stage p0: combinational op decode from the raw instruction word.
  always_comb begin
    op_p0    = '0;
    itype_p0 = 1'b0;
    shift_p0 = 1'b0;
    if (opcode == 7'b0110011) begin
      case (funct7)
        7'b0000000: begin
          case (funct3)
            3'b000:  op_p0 = OP_ADD;
            3'b001:  op_p0 = OP_SLL;
            3'b010:  op_p0 = OP_SLT;
            3'b011:  op_p0 = OP_SLTU;
            3'b100:  op_p0 = OP_XOR;
            3'b101:  op_p0 = OP_SRL;
            3'b110:  op_p0 = OP_OR;
            default: op_p0 = OP_AND;
          endcase
        end
        7'b0100000: begin
          if (funct3 == 3'b000)      op_p0 = OP_SUB;
          else if (funct3 == 3'b101) op_p0 = OP_SRA;
        end
`ifdef ALU_OP_ENCODER_MEXT_EN
        7'b0000001: begin
          case (funct3)
            3'b000:  op_p0 = OP_MUL;
            3'b100:  op_p0 = OP_DIV;
            3'b110:  op_p0 = OP_REM;
            default: op_p0 = '0;
          endcase
        end
`endif
        default: op_p0 = '0;
      endcase
    end else if (opcode == 7'b0010011) begin
      itype_p0 = 1'b1;
      case (funct3)
        3'b000: op_p0 = OP_ADD;
        3'b010: op_p0 = OP_SLT;
        3'b011: op_p0 = OP_SLTU;
        3'b100: op_p0 = OP_XOR;
        3'b110: op_p0 = OP_OR;
        3'b111: op_p0 = OP_AND;
        3'b001: begin
          shift_p0 = 1'b1;
          if (funct7 == 7'b0000000) op_p0 = OP_SLL;
        end
        default: begin
          shift_p0 = 1'b1;
          if (funct7 == 7'b0000000)      op_p0 = OP_SRL;
          else if (funct7 == 7'b0100000) op_p0 = OP_SRA;
        end
      endcase
    end
  end

  // Assemble the FIFO entry; illegal entries keep raw register fields but no immediate.
  always_comb begin
    legal_p0        = (op_p0 != '0);
    dec_p0.op       = op_p0;
    dec_p0.illegal  = ~legal_p0;
    dec_p0.rs1      = in_instr[19:15];
    dec_p0.rd       = in_instr[11:7];
    dec_p0.rs2      = in_instr[24:20];
    dec_p0.use_imm  = 1'b0;
    dec_p0.imm      = '0;
    if (legal_p0 && itype_p0) begin
      dec_p0.rs2     = '0;
      dec_p0.use_imm = 1'b1;
      dec_p0.imm     = shift_p0 ? {27'b0, in_instr[24:20]} : $unsigned(imm_i_p0);
    end
  end

  // Stage p1: FIFO storage and head presentation.
  entry_t            mem_p1 [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_BW-1:0] count;
  logic              vld_p1;
  logic              push;
  logic              pop;
  entry_t            head_p1;

  assign vld_p1   = (count != '0);
  assign in_ready = (count < DEPTH_C);
  assign push     = in_valid & in_ready;
  assign pop      = vld_p1 & out_ready;
  assign head_p1  = mem_p1[rd_ptr];

  // Control state: pointers, occupancy and the illegal counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (push && dec_p0.illegal) illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

  // Entry payload is written at push only; unread slots need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_p1[wr_ptr] <= dec_p0;
  end

  assign out_valid   = vld_p1;
  assign out_op      = vld_p1 ? head_p1.op      : '0;
  assign out_rs1     = vld_p1 ? head_p1.rs1     : '0;
  assign out_rs2     = vld_p1 ? head_p1.rs2     : '0;
  assign out_rd      = vld_p1 ? head_p1.rd      : '0;
  assign out_imm     = vld_p1 ? head_p1.imm     : '0;
  assign out_use_imm = vld_p1 ? head_p1.use_imm : 1'b0;
  assign out_illegal = vld_p1 ? head_p1.illegal : 1'b0;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Directed testbench for alu_op_encoder; honours ALU_OP_ENCODER_MEXT_EN.
module tb_alu_op_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_op;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic        out_use_imm;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_op_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_use_imm(out_use_imm), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction and hold it until accepted (bounded wait).
  task automatic push(input logic [31:0] instr);
    int waited = 0;
    in_valid = 1'b1;
    in_instr = instr;
    while (!in_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);

    // add x3, x1, x2
    out_ready = 1'b1;
    push(32'h002081B3);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_op", 32'(out_op), 32'd1);
    chk("add_rs1", 32'(out_rs1), 32'd1);
    chk("add_rs2", 32'(out_rs2), 32'd2);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_use_imm", 32'(out_use_imm), 32'd0);
    chk("add_illegal", 32'(out_illegal), 32'd0);
    // sub x3, x1, x2 (pushed while add pops)
    push(32'h402081B3);
    chk("sub_op", 32'(out_op), 32'd2);
    chk("sub_valid", 32'(out_valid), 32'd1);

    // addi x5, x0, -1
    push(32'hFFF00293);
    chk("addi_op", 32'(out_op), 32'd1);
    chk("addi_rd", 32'(out_rd), 32'd5);
    chk("addi_rs1", 32'(out_rs1), 32'd0);
    chk("addi_rs2", 32'(out_rs2), 32'd0);
    chk("addi_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_use_imm", 32'(out_use_imm), 32'd1);
    chk("addi_illegal", 32'(out_illegal), 32'd0);

    // srai x6, x7, 3
    push(32'h4033D313);
    chk("srai_op", 32'(out_op), 32'd128);
    chk("srai_rs1", 32'(out_rs1), 32'd7);
    chk("srai_rd", 32'(out_rd), 32'd6);
    chk("srai_imm", out_imm, 32'd3);
    chk("srai_use_imm", 32'(out_use_imm), 32'd1);

    // slli with funct7=0100000 is illegal; raw rs2 field kept
    push(32'h40339313);
    chk("bad_slli_op", 32'(out_op), 32'd0);
    chk("bad_slli_illegal", 32'(out_illegal), 32'd1);
    chk("bad_slli_rs2", 32'(out_rs2), 32'd3);
    chk("bad_slli_imm", out_imm, 32'd0);
    chk("bad_slli_use_imm", 32'(out_use_imm), 32'd0);
    chk("bad_slli_cnt", 32'(illegal_cnt), 32'd1);

    // mul x10, x11, x12
    push(32'h02C58533);
    chk("mul_rs1", 32'(out_rs1), 32'd11);
    chk("mul_rs2", 32'(out_rs2), 32'd12);
    chk("mul_rd", 32'(out_rd), 32'd10);
`ifdef ALU_OP_ENCODER_MEXT_EN
    chk("mul_op", 32'(out_op), 32'd1024);
    chk("mul_illegal", 32'(out_illegal), 32'd0);
    chk("mul_cnt", 32'(illegal_cnt), 32'd1);
`else
    chk("mul_op", 32'(out_op), 32'd0);
    chk("mul_illegal", 32'(out_illegal), 32'd1);
    chk("mul_cnt", 32'(illegal_cnt), 32'd2);
`endif
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: fill, hold the third, then release in order
    out_ready = 1'b0;
    push(32'h002081B3);
    push(32'h402081B3);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_instr = 32'h0020C1B3;
    step(); step();
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_head_op", 32'(out_op), 32'd1);
    chk("stall_head_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("release_op_b", 32'(out_op), 32'd2);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("release_op_c", 32'(out_op), 32'd4);
    chk("pushpop_in_ready", 32'(in_ready), 32'd1);
    chk("pushpop_valid", 32'(out_valid), 32'd1);
    step();
    chk("release_empty", 32'(out_valid), 32'd0);

    // Reset with two entries queued
    out_ready = 1'b0;
    push(32'hFFFFFFFF);
    chk("allones_illegal", 32'(out_illegal), 32'd1);
    chk("allones_rs1", 32'(out_rs1), 32'd31);
    chk("allones_rs2", 32'(out_rs2), 32'd31);
    chk("allones_rd", 32'(out_rd), 32'd31);
    push(32'h002081B3);
    chk("prerst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_cnt", 32'(illegal_cnt), 32'd0);
    chk("midrst_op", 32'(out_op), 32'd0);
    out_ready = 1'b1;
    step();
    chk("postrst_valid", 32'(out_valid), 32'd0);

    // Saturation of the illegal counter
    in_valid = 1'b1;
    in_instr = 32'hFFFFFFFF;
    for (int i = 0; i < 65535; i++) step();
    chk("sat_reach", 32'(illegal_cnt), 32'h0000FFFF);
    step();
    chk("sat_hold", 32'(illegal_cnt), 32'h0000FFFF);
    step();
    in_valid = 1'b0;
    chk("sat_hold2", 32'(illegal_cnt), 32'h0000FFFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
